// File: rtl/buffered_uart_tx.sv
// -----------------------------------------------------------------------------
// buffered_uart_tx
//
// UART transmitter with an internal TX FIFO. The host pushes words through a
// valid/ready write port; a framer pops them one at a time and serialises them
// with a start bit, 5..DATA_WIDTH data bits (LSB first), optional parity and
// one or two stop bits. Every per-frame setting (data bits, parity mode, stop
// bits, baud divisor) is latched when the frame starts, so the host may change
// the configuration inputs at any time without disturbing a frame in flight.
// A level-sensitive break request holds the line low from IDLE.
//
// Optional feature (compile-time macro UART_TX_CTS_EN):
//   Adds the cts_n input (active-low clear-to-send). It is brought in through a
//   two-flop synchroniser and gates only the start of new data frames.
//   Without the macro the port is absent and the line is treated as always
//   clear.
//
// Parameters
//   DATA_WIDTH   maximum data bits per frame (5..9)
//   FIFO_DEPTH   TX FIFO entries, power of two, >= 2
//   CNT_W        width of fifo_count (derived)
//
// Ports
//   clk            clock
//   reset          asynchronous, active-high reset
//   wr_valid       host write request
//   wr_data        word to enqueue (bits above the frame's data bits ignored)
//   wr_ready       FIFO can accept a word (= !fifo_full)
//   baud_divisor   clk cycles per serial bit, 0 behaves as 1
//   data_bits      data bits per frame, clamped to 5..DATA_WIDTH
//   parity_mode    000 none, 001 odd, 010 even, 011 mark, 100 space, else none
//   two_stop_bits  0: one stop bit, 1: two stop bits
//   tx_enable      permits new frames to start
//   send_break     level request to hold the line low (acted on from IDLE)
//   cts_n          (UART_TX_CTS_EN only) active-low clear-to-send
//   out            registered serial line, idle high
//   busy           framer is not idle
//   done           one-cycle pulse in the last cycle of a data frame's stop time
//   fifo_count     current FIFO occupancy
//   fifo_empty     FIFO holds no words
//   fifo_full      FIFO holds FIFO_DEPTH words
// -----------------------------------------------------------------------------
module buffered_uart_tx #(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic [15:0]           baud_divisor,
    input  logic [3:0]            data_bits,
    input  logic [2:0]            parity_mode,
    input  logic                  two_stop_bits,
    input  logic                  tx_enable,
    input  logic                  send_break,
`ifdef UART_TX_CTS_EN
    input  logic                  cts_n,
`endif
    output logic                  out,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  fifo_empty,
    output logic                  fifo_full
);

    localparam int         PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);
    localparam logic [3:0] MIN_BITS = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_STOP2,
        S_BREAK
    } state_t;

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    assign fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (r_count == '0);
    assign fifo_count = r_count;
    // A full FIFO refuses writes even when the framer pops in the same cycle.
    assign wr_ready   = !fifo_full;
    assign w_push     = wr_valid && !fifo_full;

    // NOTE: the storage array has no reset; the occupancy count alone decides
    // which entries are valid, so clearing the data would only add logic.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Clear-to-send gating
    // -------------------------------------------------------------------------
    logic w_cts_ok;

`ifdef UART_TX_CTS_EN
    logic [1:0] r_cts_sync;

    // Resets to "not clear" so nothing starts until cts_n is seen low twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cts_sync <= 2'b11;
        end else begin
            r_cts_sync <= {r_cts_sync[0], cts_n};
        end
    end

    assign w_cts_ok = !r_cts_sync[1];
`else
    assign w_cts_ok = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Frame configuration decode (values captured when a frame starts)
    // -------------------------------------------------------------------------
    logic [3:0]            w_nbits;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_head_masked;
    logic                  w_par_en_in;
    logic                  w_par_bit_in;
    logic [15:0]           w_div_m1_in;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_nbits = data_bits;
        if (data_bits < MIN_BITS) begin
            w_nbits = MIN_BITS;
        end else if (data_bits > MAX_BITS) begin
            w_nbits = MAX_BITS;
        end
        w_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_mask[i] = (i < int'(w_nbits));
        end
    end

    // Unused upper bits are zeroed so parity covers only the transmitted bits.
    assign w_head_masked = r_mem[r_rd_ptr] & w_mask;
    assign w_div_m1_in   = (baud_divisor == 16'd0) ? 16'd0 : baud_divisor - 16'd1;

    always_comb begin
        w_par_en_in  = 1'b1;
        w_par_bit_in = 1'b0;
        case (parity_mode)
            3'b001:  w_par_bit_in = ~^w_head_masked;
            3'b010:  w_par_bit_in = ^w_head_masked;
            3'b011:  w_par_bit_in = 1'b1;
            3'b100:  w_par_bit_in = 1'b0;
            default: w_par_en_in  = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Framer FSM
    // -------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_next_state;
    logic                  r_out;
    logic                  w_out_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [3:0]            r_bit_idx;
    logic [3:0]            r_nbits;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_two_stop;
    logic                  r_is_break;
    logic [15:0]           r_div_m1;
    logic [15:0]           r_baud_cnt;

    logic w_tick;
    logic w_can_start;
    logic w_idle_pick;
    logic w_start_frame;
    logic w_start_break;
    logic w_reload;
    logic w_shift;
    logic w_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_out   <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_out   <= w_out_next;
        end
    end

    always_comb begin
        w_tick        = (r_baud_cnt == 16'd0);
        w_can_start   = !fifo_empty && tx_enable && w_cts_ok;
        w_next_state  = r_state;
        w_out_next    = r_out;
        w_idle_pick   = 1'b0;
        w_start_frame = 1'b0;
        w_start_break = 1'b0;
        w_reload      = 1'b0;
        w_shift       = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_idle_pick = 1'b1;
            end
            S_START: begin
                if (w_tick) begin
                    w_next_state = S_DATA;
                    w_out_next   = r_shift[0];
                    w_reload     = 1'b1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_reload = 1'b1;
                    if (r_bit_idx == r_nbits - 4'd1) begin
                        if (r_par_en) begin
                            w_next_state = S_PARITY;
                            w_out_next   = r_par_bit;
                        end else begin
                            w_next_state = S_STOP;
                            w_out_next   = 1'b1;
                        end
                    end else begin
                        w_shift    = 1'b1;
                        w_out_next = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_next_state = S_STOP;
                    w_out_next   = 1'b1;
                    w_reload     = 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_two_stop) begin
                        w_next_state = S_STOP2;
                        w_reload     = 1'b1;
                    end else if (r_is_break) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_done      = 1'b1;
                        w_idle_pick = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (w_tick) begin
                    if (r_is_break) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_done      = 1'b1;
                        w_idle_pick = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (!send_break) begin
                    w_next_state = S_STOP;
                    w_out_next   = 1'b1;
                    w_reload     = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_out_next   = 1'b1;
            end
        endcase

        // IDLE decision, also taken at the end of a data frame's stop time so
        // a queued word starts with no idle cycle in between.
        if (w_idle_pick) begin
            if (send_break) begin
                w_next_state  = S_BREAK;
                w_out_next    = 1'b0;
                w_start_break = 1'b1;
            end else if (w_can_start) begin
                w_next_state  = S_START;
                w_out_next    = 1'b0;
                w_start_frame = 1'b1;
            end else begin
                w_next_state  = S_IDLE;
                w_out_next    = 1'b1;
            end
        end
    end

    assign w_pop = w_start_frame;

    // Frame registers and baud down-counter: each bit lasts divisor cycles,
    // the counter reloads divisor-1 and the bit ends on the cycle it reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_nbits    <= MIN_BITS;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_is_break <= 1'b0;
            r_div_m1   <= '0;
            r_baud_cnt <= '0;
        end else if (w_start_frame) begin
            r_shift    <= w_head_masked;
            r_bit_idx  <= '0;
            r_nbits    <= w_nbits;
            r_par_en   <= w_par_en_in;
            r_par_bit  <= w_par_bit_in;
            r_two_stop <= two_stop_bits;
            r_is_break <= 1'b0;
            r_div_m1   <= w_div_m1_in;
            r_baud_cnt <= w_div_m1_in;
        end else if (w_start_break) begin
            // The stop time after a break uses the settings seen on entry.
            r_two_stop <= two_stop_bits;
            r_is_break <= 1'b1;
            r_div_m1   <= w_div_m1_in;
            r_baud_cnt <= w_div_m1_in;
        end else begin
            if (w_reload) begin
                r_baud_cnt <= r_div_m1;
            end else if (!w_tick) begin
                r_baud_cnt <= r_baud_cnt - 16'd1;
            end
            if (w_shift) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 4'd1;
            end
        end
    end

    assign out  = r_out;
    assign busy = (r_state != S_IDLE);
    assign done = w_done;

endmodule

// File: tb/tb_buffered_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_buffered_uart_tx
//
// Self-checking bench for buffered_uart_tx. Stimulus pushes an expected-frame
// record (word plus the configuration in force) into a scoreboard queue; an
// independent monitor watches the serial line, and on every start bit pops the
// next record, expands it into the ideal per-cycle line levels and compares
// each cycle, including the done pulse on the final cycle.
// -----------------------------------------------------------------------------
module tb_buffered_uart_tx;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [15:0]   baud_divisor;
    logic [3:0]    data_bits;
    logic [2:0]    parity_mode;
    logic          two_stop_bits;
    logic          tx_enable;
    logic          send_break;
    logic          tx_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
`ifdef UART_TX_CTS_EN
    logic          cts_n;
`endif

    buffered_uart_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .baud_divisor  (baud_divisor),
        .data_bits     (data_bits),
        .parity_mode   (parity_mode),
        .two_stop_bits (two_stop_bits),
        .tx_enable     (tx_enable),
        .send_break    (send_break),
`ifdef UART_TX_CTS_EN
        .cts_n         (cts_n),
`endif
        .out           (tx_out),
        .busy          (busy),
        .done          (done),
        .fifo_count    (fifo_count),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         bits;
        int         par;
        bit         two;
    } exp_t;

    typedef bit bit_q_t[$];

    exp_t exp_q[$];
    int   start_q[$];
    bit   mon_en     = 1'b0;
    bit   in_frame   = 1'b0;
    int   stray_done = 0;
    int   checks     = 0;
    int   failures   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: ideal line level for every clock cycle of a frame
    // ---------------------------------------------------------------------
    function automatic bit_q_t frame_levels(input exp_t e);
        bit_q_t lv;
        int     d    = (e.div == 0) ? 1 : e.div;
        int     n    = (e.bits < 5) ? 5 : ((e.bits > DW) ? DW : e.bits);
        int     ones = 0;
        bit     has_p = 1'b1;
        bit     p     = 1'b0;
        repeat (d) lv.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            repeat (d) lv.push_back(e.data[i]);
            ones += int'(e.data[i]);
        end
        case (e.par)
            1:       p = (ones % 2 == 0);  // total count of ones made odd
            2:       p = (ones % 2 == 1);  // total count of ones made even
            3:       p = 1'b1;
            4:       p = 1'b0;
            default: has_p = 1'b0;
        endcase
        if (has_p) repeat (d) lv.push_back(p);
        repeat (e.two ? 2 * d : d) lv.push_back(1'b1);
        return lv;
    endfunction

    // ---------------------------------------------------------------------
    // Monitor: detects start bits and compares whole frames cycle by cycle
    // ---------------------------------------------------------------------
    initial begin
        bit     prev = 1'b1;
        bit_q_t lv;
        exp_t   e;
        int     nerr;
        int     derr;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) begin
                prev = tx_out;
            end else if (prev && !tx_out) begin
                start_q.push_back(cyc);
                check("sb_has_entry", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e        = exp_q.pop_front();
                    lv       = frame_levels(e);
                    nerr     = 0;
                    derr     = 0;
                    in_frame = 1'b1;
                    for (int k = 0; k < lv.size(); k++) begin
                        if (k > 0) @(negedge clk);
                        if (!mon_en) break;
                        if (tx_out !== lv[k]) nerr++;
                        if (done !== (k == lv.size() - 1)) derr++;
                    end
                    if (mon_en) begin
                        check($sformatf("frame_levels_%02h", e.data), nerr, 0);
                        check($sformatf("frame_done_%02h", e.data), derr, 0);
                    end
                    in_frame = 1'b0;
                end
                prev = tx_out;
            end else begin
                if (done === 1'b1) stray_done++;
                prev = tx_out;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (inputs change 1ns after the rising edge)
    // ---------------------------------------------------------------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int div, input int bits, input int par, input bit two);
        baud_divisor  = 16'(div);
        data_bits     = 4'(bits);
        parity_mode   = 3'(par);
        two_stop_bits = two;
    endtask

    // Caller is aligned 1ns after a rising edge; returns aligned the same way.
    task automatic push_word(input logic [7:0] w, input bit expect_accept);
        exp_t e;
        wr_data  = w;
        wr_valid = 1'b1;
        check("wr_ready", wr_ready, expect_accept);
        if (expect_accept) begin
            e.data = w;
            e.div  = int'(baud_divisor);
            e.bits = int'(data_bits);
            e.par  = int'(parity_mode);
            e.two  = two_stop_bits;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy === 1'b0 && fifo_empty === 1'b1 && !in_frame) && n < max_cycles);
        check("idle_timeout", (n >= max_cycles), 0);
        check("sb_drained", exp_q.size(), 0);
        sync();
    endtask

    task automatic wait_in_frame(input int max_cycles);
        int n = 0;
        while (!in_frame && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_timeout", (n >= max_cycles), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        int low_bad;
        int high_bad;
        int done_cnt;
        int gap_bad;
        int n;

        reset      = 1'b1;
        wr_valid   = 1'b0;
        wr_data    = '0;
        tx_enable  = 1'b1;
        send_break = 1'b0;
        set_cfg(4, 8, 0, 0);
`ifdef UART_TX_CTS_EN
        cts_n      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", fifo_count, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_wr_ready", wr_ready, 1);
        reset = 1'b0;
        repeat (3) sync();
        mon_en = 1'b1;

        // 8N1 at divisor 4, 0xA5, with start latency
        set_cfg(4, 8, 0, 0);
        push_word(8'hA5, 1);
        @(negedge clk);
        check("lat_out_idle", tx_out, 1);
        check("lat_count", fifo_count, 1);
        @(negedge clk);
        check("lat_out_start", tx_out, 0);
        check("lat_busy", busy, 1);
        check("lat_popped", fifo_count, 0);
        wait_idle(200);

        // 7 data bits, odd parity, two stop bits, 0x41
        set_cfg(3, 7, 1, 1);
        push_word(8'h41, 1);
        wait_idle(200);

        // configuration changed while a frame is in flight
        set_cfg(3, 8, 2, 0);
        push_word(8'h3C, 1);
        wait_in_frame(50);
        set_cfg(5, 6, 3, 1);
        wait_idle(300);
        push_word(8'h96, 1);
        wait_idle(300);

        // fill the FIFO with transmission disabled, then drain back-to-back
        tx_enable = 1'b0;
        set_cfg(2, 8, 0, 0);
        for (int i = 0; i < DEPTH; i++) push_word(8'($urandom), 1);
        push_word(8'hFF, 0);
        check("full_flag", fifo_full, 1);
        check("full_wr_ready", wr_ready, 0);
        check("full_count", fifo_count, DEPTH);
        check("full_idle", busy, 0);
        start_q.delete();
        tx_enable = 1'b1;
        wait_idle(DEPTH * 20 + 100);
        check("b2b_frames", start_q.size(), DEPTH);
        gap_bad = 0;
        for (int i = 1; i < start_q.size(); i++) begin
            if (start_q[i] - start_q[i-1] != 20) gap_bad++;
        end
        check("b2b_gap", gap_bad, 0);

        // tx_enable dropped mid-frame: frame completes, next word waits
        set_cfg(4, 8, 0, 0);
        push_word(8'h11, 1);
        push_word(8'h22, 1);
        wait_in_frame(50);
        repeat (5) @(negedge clk);
        tx_enable = 1'b0;
        repeat (60) @(negedge clk);
        check("txen_busy", busy, 0);
        check("txen_out", tx_out, 1);
        check("txen_count", fifo_count, 1);
        sync();
        tx_enable = 1'b1;
        wait_idle(200);

        // break for 100 cycles at divisor 8
        mon_en = 1'b0;
        set_cfg(8, 8, 0, 0);
        sync();
        send_break = 1'b1;
        low_bad  = 0;
        high_bad = 0;
        done_cnt = 0;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b0) low_bad++;
            if (done === 1'b1) done_cnt++;
        end
        send_break = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b1) high_bad++;
            if (done === 1'b1) done_cnt++;
        end
        @(negedge clk);
        check("brk_low", low_bad, 0);
        check("brk_stop_high", high_bad, 0);
        check("brk_no_done", done_cnt, 0);
        check("brk_busy_fall", busy, 0);
        check("brk_out_idle", tx_out, 1);
        sync();
        mon_en = 1'b1;

        // asynchronous reset in the middle of the data bits
        set_cfg(4, 8, 0, 0);
        push_word(8'h5A, 1);
        push_word(8'hC3, 1);
        wait_in_frame(50);
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out", tx_out, 1);
        check("arst_busy", busy, 0);
        check("arst_count", fifo_count, 0);
        check("arst_empty", fifo_empty, 1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        sync();
        mon_en = 1'b1;
        push_word(8'h69, 1);
        wait_idle(200);

`ifdef UART_TX_CTS_EN
        // clear-to-send gating
        cts_n = 1'b1;
        repeat (4) sync();
        set_cfg(4, 8, 0, 0);
        push_word(8'hB7, 1);
        repeat (20) @(negedge clk);
        check("cts_hold_busy", busy, 0);
        check("cts_hold_out", tx_out, 1);
        check("cts_hold_count", fifo_count, 1);
        sync();
        cts_n = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_out !== 1'b0 && n < 10);
        check("cts_latency", n, 3);
        repeat (10) @(negedge clk);
        cts_n = 1'b1;
        wait_idle(200);
        cts_n = 1'b0;
        repeat (3) sync();
`endif

        // randomized bursts with random configuration
        for (int b = 0; b < 10; b++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 15),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) push_word(8'($urandom), 1);
            wait_idle(1000);
        end

        check("stray_done", stray_done, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
